// File: rtl/alu_exec_stage.sv
// Issue/writeback stage around an external combinational ALU: reads operands from a
// small register file, waits one ALU cycle, then presents and retires the result.
module alu_exec_stage #(
  parameter int WIDTH = 16,
  parameter int NREG  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [1:0]       in_rd,
  input  logic [1:0]       in_rs,
  input  logic [1:0]       in_rt,
  input  logic [WIDTH-1:0] in_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [1:0]       out_rd,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  input  logic [1:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [2:0] OP_LDI = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_regs [NREG];
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [WIDTH-1:0] r_out_result;
  logic [1:0]       r_alu_op;
  logic [1:0]       r_out_rd;
  logic             r_flag_z;
  logic             r_flag_c;
  logic             r_flag_n;
  logic             r_wb_pending;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_is_alu;
  logic             w_is_ldi;
  logic             w_wb_write;

  assign w_is_alu   = (in_op[2] == 1'b0);
  assign w_is_ldi   = (in_op == OP_LDI);
  assign w_accept   = in_valid & w_in_ready;
  // The register file is written once, in the first WB cycle, however long WB stalls.
  assign w_wb_write = w_out_valid & r_wb_pending;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; reserved opcodes are consumed in IDLE as NOPs.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid && w_is_alu) begin
          w_next_state = S_EXEC;
        end else if (in_valid && w_is_ldi) begin
          w_next_state = S_WB;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_EXEC: w_next_state = S_WB;
      S_WB: begin
        if (out_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_WB;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE:  w_in_ready  = 1'b1;
      S_WB:    w_out_valid = 1'b1;
      default: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
      end
    endcase
  end

  // Operand capture, result capture and flag update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a      <= {WIDTH{1'b0}};
      r_alu_b      <= {WIDTH{1'b0}};
      r_alu_op     <= 2'b00;
      r_out_result <= {WIDTH{1'b0}};
      r_out_rd     <= 2'b00;
      r_flag_z     <= 1'b0;
      r_flag_c     <= 1'b0;
      r_flag_n     <= 1'b0;
    end else if (w_accept && w_is_alu) begin
      r_alu_a  <= r_regs[in_rs];
      r_alu_b  <= r_regs[in_rt];
      r_alu_op <= in_op[1:0];
      r_out_rd <= in_rd;
    end else if (w_accept && w_is_ldi) begin
      r_out_result <= in_imm;
      r_out_rd     <= in_rd;
      r_flag_z     <= (in_imm == {WIDTH{1'b0}});
      r_flag_c     <= 1'b0;
      r_flag_n     <= in_imm[WIDTH-1];
    end else if (r_state == S_EXEC) begin
      r_out_result <= alu_y;
      r_flag_z     <= (alu_y == {WIDTH{1'b0}});
      // Carry is meaningful only for ADD/SUB (op[1] clear).
      r_flag_c     <= alu_cout & ~r_alu_op[1];
      r_flag_n     <= alu_y[WIDTH-1];
    end
  end

  // Register file and the one-shot writeback marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= {WIDTH{1'b0}};
      end
      r_wb_pending <= 1'b0;
    end else begin
      if (w_wb_write) begin
        r_regs[r_out_rd] <= r_out_result;
      end
      if ((w_accept && w_is_ldi) || (r_state == S_EXEC)) begin
        r_wb_pending <= 1'b1;
      end else if (w_wb_write) begin
        r_wb_pending <= 1'b0;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = w_out_valid;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign out_result = r_out_result;
  assign out_rd     = r_out_rd;
  assign flag_z     = r_flag_z;
  assign flag_c     = r_flag_c;
  assign flag_n     = r_flag_n;
  assign dbg_data   = r_regs[dbg_sel];

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: behavioural ALU on the ALU ports, directed scenarios and
// random instruction streams checked against an arithmetic register-file model.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [1:0]  in_rd, in_rs, in_rt;
  logic [15:0] in_imm;
  logic [15:0] alu_a, alu_b, alu_y;
  logic [1:0]  alu_op;
  logic        alu_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [1:0]  out_rd;
  logic        flag_z, flag_c, flag_n;
  logic [1:0]  dbg_sel;
  logic [15:0] dbg_data;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [15:0] m_reg [4];
  logic        m_z, m_c, m_n;

  // Observed / expected values of the last instruction.
  logic [15:0] o_res, e_res;
  logic [1:0]  o_rd;
  logic [2:0]  o_f;
  logic        e_c;
  int          o_lat;

  always #5 clk = ~clk;

  // External ALU as the stage sees it.
  always_comb begin
    alu_y    = 16'h0000;
    alu_cout = 1'b0;
    case (alu_op)
      2'd0:    {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      2'd1:    {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
      2'd2:    alu_y = alu_a & alu_b;
      default: alu_y = alu_a | alu_b;
    endcase
  end

  alu_exec_stage #(.WIDTH(16), .NREG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 16'h0000;
    m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;
  endfunction

  // Architectural effect of one instruction, from the opcode definitions.
  function automatic void ref_exec(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                                   input logic [1:0] rt, input logic [15:0] imm,
                                   output logic [15:0] r, output logic c);
    int unsigned a, b, s;
    a = m_reg[rs]; b = m_reg[rt]; r = 16'h0000; c = 1'b0; s = 0;
    case (op)
      3'd0: begin s = a + b; r = s[15:0]; c = (s > 32'd65535); end
      3'd1: begin s = a - b; r = s[15:0]; c = (a >= b); end
      3'd2: r = m_reg[rs] & m_reg[rt];
      3'd3: r = m_reg[rs] | m_reg[rt];
      3'd4: r = imm;
      default: r = 16'h0000;
    endcase
    if (op <= 3'd4) begin
      m_reg[rd] = r; m_z = (r == 16'h0000); m_n = r[15]; m_c = c;
    end
  endfunction

  // Present one instruction and return #1 after the edge that accepts it.
  task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                      input logic [1:0] rt, input logic [15:0] imm);
    int cnt;
    @(negedge clk);
    in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm; in_valid = 1'b1;
    cnt = 0;
    while (in_ready !== 1'b1 && cnt < 20) begin @(negedge clk); cnt++; end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL accept_timeout in_ready=%b required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Run one instruction to completion; stall = WB cycles spent with out_ready low.
  task automatic exec_op(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [1:0] rt, input logic [15:0] imm, input int stall);
    ref_exec(op, rd, rs, rt, imm, e_res, e_c);
    out_ready = (stall == 0);
    send(op, rd, rs, rt, imm);
    o_lat = 1; o_res = 16'h0000; o_rd = 2'b00; o_f = 3'b000;
    if (op <= 3'd4) begin
      while (out_valid !== 1'b1 && o_lat < 10) begin @(posedge clk); #1; o_lat++; end
      o_res = out_result; o_rd = out_rd; o_f = {flag_z, flag_c, flag_n};
      repeat (stall) @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_cmp++; if ({out_result, out_rd} !== 18'h0) begin n_err++; $display("FAIL rst_out got %h/%0d exp 0", out_result, out_rd); end
    n_cmp++; if ({flag_z, flag_c, flag_n} !== 3'b000) begin n_err++; $display("FAIL rst_flags got %b exp 000", {flag_z, flag_c, flag_n}); end
    n_cmp++; if ({alu_a, alu_b, alu_op} !== 34'h0) begin n_err++; $display("FAIL rst_alu got %h %h %0d exp 0", alu_a, alu_b, alu_op); end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      n_cmp++; if (dbg_data !== 16'h0000) begin n_err++; $display("FAIL rst_reg%0d got %h exp 0000", i, dbg_data); end
    end
  endtask

  task automatic test_add_basic();
    exec_op(3'd4, 2'd1, 2'd0, 2'd0, 16'h0005, 0);
    n_cmp++; if (o_lat != 1) begin n_err++; $display("FAIL ldi_latency got %0d exp 1", o_lat); end
    n_cmp++; if ({o_res, o_rd} !== {16'h0005, 2'd1}) begin n_err++; $display("FAIL ldi_result got %h/%0d exp 0005/1", o_res, o_rd); end
    exec_op(3'd4, 2'd2, 2'd0, 2'd0, 16'h0003, 0);
    exec_op(3'd0, 2'd3, 2'd1, 2'd2, 16'h0000, 0);
    n_cmp++; if (o_lat != 2) begin n_err++; $display("FAIL add_latency got %0d exp 2", o_lat); end
    n_cmp++; if ({o_res, o_rd} !== {16'h0008, 2'd3}) begin n_err++; $display("FAIL add_result got %h/%0d exp 0008/3", o_res, o_rd); end
    n_cmp++; if (o_f !== 3'b000) begin n_err++; $display("FAIL add_flags got %b exp 000", o_f); end
    dbg_sel = 2'd3; #1;
    n_cmp++; if (dbg_data !== 16'h0008) begin n_err++; $display("FAIL add_dbg got %h exp 0008", dbg_data); end
  endtask

  task automatic test_add_carry();
    exec_op(3'd4, 2'd1, 2'd0, 2'd0, 16'hFFFF, 0);
    exec_op(3'd4, 2'd2, 2'd0, 2'd0, 16'h0001, 0);
    exec_op(3'd0, 2'd0, 2'd1, 2'd2, 16'h0000, 0);
    n_cmp++; if (o_res !== 16'h0000) begin n_err++; $display("FAIL addc_result got %h exp 0000", o_res); end
    n_cmp++; if (o_f !== 3'b110) begin n_err++; $display("FAIL addc_flags zcn got %b exp 110", o_f); end
  endtask

  task automatic test_sub();
    exec_op(3'd4, 2'd1, 2'd0, 2'd0, 16'h0003, 0);
    exec_op(3'd4, 2'd2, 2'd0, 2'd0, 16'h0005, 0);
    exec_op(3'd1, 2'd0, 2'd1, 2'd2, 16'h0000, 0);
    n_cmp++; if (o_res !== 16'hFFFE) begin n_err++; $display("FAIL sub_borrow_result got %h exp fffe", o_res); end
    n_cmp++; if (o_f !== 3'b001) begin n_err++; $display("FAIL sub_borrow_flags zcn got %b exp 001", o_f); end
    exec_op(3'd1, 2'd0, 2'd2, 2'd1, 16'h0000, 0);
    n_cmp++; if (o_res !== 16'h0002) begin n_err++; $display("FAIL sub_result got %h exp 0002", o_res); end
    n_cmp++; if (o_f !== 3'b010) begin n_err++; $display("FAIL sub_flags zcn got %b exp 010", o_f); end
  endtask

  task automatic test_logic();
    exec_op(3'd4, 2'd1, 2'd0, 2'd0, 16'h00F0, 0);
    exec_op(3'd4, 2'd2, 2'd0, 2'd0, 16'h0F0F, 0);
    exec_op(3'd2, 2'd0, 2'd1, 2'd2, 16'h0000, 0);
    n_cmp++; if ({o_res, o_f} !== {16'h0000, 3'b100}) begin n_err++; $display("FAIL and_out got %h/%b exp 0000/100", o_res, o_f); end
    exec_op(3'd3, 2'd3, 2'd1, 2'd2, 16'h0000, 0);
    n_cmp++; if ({o_res, o_f} !== {16'h0FFF, 3'b000}) begin n_err++; $display("FAIL or_out got %h/%b exp 0fff/000", o_res, o_f); end
  endtask

  task automatic test_stall();
    int cnt;
    exec_op(3'd4, 2'd1, 2'd0, 2'd0, 16'h1234, 0);
    exec_op(3'd4, 2'd2, 2'd0, 2'd0, 16'h4321, 0);
    ref_exec(3'd0, 2'd3, 2'd1, 2'd2, 16'h0000, e_res, e_c);
    out_ready = 1'b0; dbg_sel = 2'd3;
    send(3'd0, 2'd3, 2'd1, 2'd2, 16'h0000);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 10) begin @(posedge clk); #1; cnt++; end
    n_cmp++; if (out_result !== 16'h5555) begin n_err++; $display("FAIL stall_result got %h exp 5555", out_result); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, in_ready, out_result, out_rd, flag_z, flag_c, flag_n} !== {1'b1, 1'b0, 16'h5555, 2'd3, m_z, m_c, m_n}) begin
        n_err++; $display("FAIL stall_hold cyc%0d got v=%b r=%b %h/%0d %b exp v=1 r=0 5555/3 %b", i, out_valid, in_ready,
                          out_result, out_rd, {flag_z, flag_c, flag_n}, {m_z, m_c, m_n});
      end
      n_cmp++; if (dbg_data !== 16'h5555) begin n_err++; $display("FAIL stall_reg cyc%0d got %h exp 5555", i, dbg_data); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL stall_release got ready=%b valid=%b exp 1/0", in_ready, out_valid); end
  endtask

  task automatic test_reset_midflight();
    exec_op(3'd4, 2'd1, 2'd0, 2'd0, 16'h8000, 0);
    out_ready = 1'b1;
    send(3'd0, 2'd0, 2'd1, 2'd1, 16'h0000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL mid_rst_state got ready=%b valid=%b exp 1/0", in_ready, out_valid); end
    n_cmp++; if ({out_result, flag_z, flag_c, flag_n} !== 19'h0) begin n_err++; $display("FAIL mid_rst_out got %h %b exp 0", out_result, {flag_z, flag_c, flag_n}); end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      n_cmp++; if (dbg_data !== 16'h0000) begin n_err++; $display("FAIL mid_rst_reg%0d got %h exp 0000", i, dbg_data); end
    end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_drop got valid=%b exp 0", out_valid); end
    exec_op(3'd4, 2'd2, 2'd0, 2'd0, 16'h8001, 0);
    exec_op(3'd6, 2'd2, 2'd1, 2'd1, 16'h0007, 0);
    dbg_sel = 2'd2; #1;
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL nop_state got ready=%b valid=%b exp 1/0", in_ready, out_valid); end
    n_cmp++; if ({dbg_data, flag_z, flag_c, flag_n} !== {16'h8001, 3'b001}) begin n_err++; $display("FAIL nop_effect got %h %b exp 8001 001", dbg_data, {flag_z, flag_c, flag_n}); end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [1:0] rd;
    int stall;
    for (int k = 0; k < 150; k++) begin
      op    = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
      rd    = 2'($urandom_range(0, 3));
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      exec_op(op, rd, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom), stall);
      if (op <= 3'd4) begin
        n_cmp++;
        if (o_lat != ((op == 3'd4) ? 1 : 2) || o_res !== e_res || o_rd !== rd || o_f !== {m_z, m_c, m_n}) begin
          n_err++; $display("FAIL rnd_op%0d #%0d got lat=%0d %h/%0d %b exp %h/%0d %b", op, k, o_lat, o_res, o_rd, o_f,
                            e_res, rd, {m_z, m_c, m_n});
        end
        dbg_sel = rd; #1;
        n_cmp++; if (dbg_data !== m_reg[rd]) begin n_err++; $display("FAIL rnd_reg #%0d got %h exp %h", k, dbg_data, m_reg[rd]); end
      end else begin
        n_cmp++;
        if ({in_ready, out_valid, flag_z, flag_c, flag_n} !== {1'b1, 1'b0, m_z, m_c, m_n}) begin
          n_err++; $display("FAIL rnd_nop #%0d got r=%b v=%b %b exp 1/0 %b", k, in_ready, out_valid, {flag_z, flag_c, flag_n}, {m_z, m_c, m_n});
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      n_cmp++; if (dbg_data !== m_reg[i]) begin n_err++; $display("FAIL rnd_final_reg%0d got %h exp %h", i, dbg_data, m_reg[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) ref_exec(3'd0, 2'd3, 2'd1, 2'd2, 16'h0000, e_res, e_c);
    @(negedge clk);
    in_op = 3'd0; in_rd = 2'd3; in_rs = 2'd1; in_rt = 2'd2; in_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (out_valid === 1'b1) cnt++; end
    in_valid = 1'b0;
    n_cmp++; if (cnt != 4) begin n_err++; $display("FAIL b2b_alu_results got %0d exp 4", cnt); end
    for (int i = 0; i < 4; i++) ref_exec(3'd4, 2'd0, 2'd0, 2'd0, 16'h0042, e_res, e_c);
    @(negedge clk);
    in_op = 3'd4; in_rd = 2'd0; in_imm = 16'h0042; in_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (out_valid === 1'b1) cnt++; end
    in_valid = 1'b0;
    n_cmp++; if (cnt != 4) begin n_err++; $display("FAIL b2b_ldi_results got %0d exp 4", cnt); end
    dbg_sel = 2'd3; #1;
    n_cmp++; if (dbg_data !== m_reg[3]) begin n_err++; $display("FAIL b2b_reg3 got %h exp %h", dbg_data, m_reg[3]); end
    dbg_sel = 2'd0; #1;
    n_cmp++; if (dbg_data !== 16'h0042) begin n_err++; $display("FAIL b2b_reg0 got %h exp 0042", dbg_data); end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_rd = 2'd0; in_rs = 2'd0; in_rt = 2'd0;
    in_imm = 16'h0000; out_ready = 1'b1; dbg_sel = 2'd0;
    model_reset();
    test_reset();
    test_add_basic();
    test_add_carry();
    test_sub();
    test_logic();
    test_stall();
    test_reset_midflight();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Execution front-end that feeds the 16-bit ripple ALU and consumes its result. It accepts register-to-register instructions over a valid/ready handshake. It reads operands from a 4-entry x 16-bit register file and drives alu_a/alu_b/alu_op to the external ALU. It captures alu_y/alu_cout, writes the result back, updates status flags and presents the result downstream over a second valid/ready handshake.

Parameters:
WIDTH, 16, datapath width; must match the ALU instance.
NREG, 4, register-file depth; register index width is 2.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  instruction present
in_ready  output  1  stage can accept an instruction
in_op  input  3  0=ADD 1=SUB 2=AND 3=OR 4=LDI; 5-7 reserved
in_rd  input  2  destination register
in_rs  input  2  source A register
in_rt  input  2  source B register
in_imm  input  WIDTH  immediate for LDI
alu_a  output  WIDTH  ALU operand i0
alu_b  output  WIDTH  ALU operand i1
alu_op  output  2  ALU op code: 00 add, 01 sub, 10 and, 11 or
alu_y  input  WIDTH  ALU result
alu_cout  input  1  ALU carry out
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_result  output  WIDTH  result of the completed instruction
out_rd  output  2  destination of the completed instruction
flag_z  output  1  zero flag
flag_c  output  1  carry flag
flag_n  output  1  negative flag (result MSB)
dbg_sel  input  2  register-file debug read select
dbg_data  output  WIDTH  combinational read of reg[dbg_sel]

Behaviour:
- Reset: rst sampled high at a clk edge. State=IDLE; all registers, alu_a, alu_b, alu_op, out_result, out_rd, flags = 0; out_valid=0. Reset overrides every other event, including an instruction mid-flight; a pending result is dropped.
- in_ready=1 only in IDLE. Accept = in_valid & in_ready at a clock edge.
- FSM states: IDLE, EXEC, WB.
- IDLE, accept of op 0-3:
  - Register alu_a=reg[rs], alu_b=reg[rt], alu_op=in_op[1:0], rd.
  - Go to EXEC.
  - Operands are captured at accept, so rd==rs/rt aliasing needs no special handling.
- IDLE, accept of LDI: out_result=in_imm, rd latched; go directly to WB.
- IDLE, accept of op 5-7: instruction consumed, no state change, stay IDLE (NOP).
- EXEC, one cycle: ALU settles combinationally. At the end-of-cycle edge, out_result<=alu_y and flags are updated; go to WB.
- WB:
  - out_valid=1 and reg[rd]=out_result is written, both in the first WB cycle.
  - Write happens once even if WB stalls.
  - Stay in WB while out_ready=0; out_result, out_rd and flags hold stable.
  - On out_ready=1, go to IDLE.
- Latency: accept edge T, out_valid high from T+2 (ALU ops) or T+1 (LDI). Throughput 1 instruction per 3 cycles (ALU ops) / 2 cycles (LDI) with out_ready tied high.
- Flags, updated only on completion of a non-NOP instruction:
  - flag_z = (result==0).
  - flag_n = result[WIDTH-1].
  - flag_c = alu_cout for ADD/SUB, 0 for AND/OR/LDI.
  - SUB carry: carry=1 means no borrow (a>=b unsigned).
- Arithmetic: ALU wraps modulo 2^WIDTH; no saturation.
- alu_a/alu_b/alu_op hold their last values outside EXEC.
- dbg_data is purely combinational. It shows the written value from the cycle after the write edge.
- in_valid while not ready: instruction must be held by the source; no capture.

Test Plan:
- Reset then LDI r1=0x0005, LDI r2=0x0003, ADD r3=r1+r2 -> out_result=0x0008, out_rd=3, z=0 c=0 n=0; out_valid two cycles after ADD accept; dbg_sel=3 reads 0x0008.
- r1=0xFFFF, r2=0x0001, ADD r0 -> out_result=0x0000, z=1 c=1 n=0.
- r1=0x0003, r2=0x0005, SUB r0 -> 0xFFFE, c=0 n=1 z=0; swap operands -> 0x0002, c=1.
- r1=0x00F0, r2=0x0F0F: AND -> 0x0000 with z=1 c=0; OR -> 0x0FFF with z=0.
- ADD with out_ready=0 for 4 cycles -> out_valid, out_result and flags stable, in_ready=0, reg[rd] written exactly once; out_ready=1 -> IDLE next cycle, in_ready=1.
- Assert rst during EXEC -> next cycle IDLE, out_valid=0, all registers and flags 0; op=6 accepted -> no register/flag change, in_ready stays 1.
